parity_frame_checker: RTL and testbench
=======================================

Name: parity_frame_checker

Overview:
- Serial successor to the 3-input combinational odd-parity cell. Receives a frame of DATA_W data bits followed by one parity bit, one bit per valid cycle.
- Checks the frame against a per-frame odd/even mode and returns the deserialised word with a pass/fail flag.
- Keeps a saturating frame-error counter.
- Sits between a serial link front-end and the status/CSR block.

Parameters:
- DATA_W, 8, data bits per frame (>=1); parity bit follows the last data bit.
- CNT_W, 8, width of the saturating error counter (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  frame-start strobe; honoured only in IDLE.
- odd_mode  input  1  1 = odd parity, 0 = even parity; sampled with start.
- bit_in  input  1  serial data/parity bit, LSB of data first.
- bit_valid  input  1  bit_in is valid this cycle.
- abort  input  1  drop the current frame and return to IDLE.
- clr_cnt  input  1  synchronous clear of err_count.
- busy  output  1  high in DATA and PARITY states.
- done  output  1  one-cycle pulse when a frame completes.
- parity_ok  output  1  result of the last completed frame.
- data_out  output  DATA_W  data bits of the last completed frame, bit 0 = first received.
- err_count  output  CNT_W  number of failed frames, saturating.

Behaviour:
- Reset (async, rst=1): state IDLE, bit index 0, accumulator 0. busy=0, done=0, parity_ok=0, data_out=0, err_count=0. Effect is immediate, including mid-frame.
- States are IDLE, DATA and PARITY. All registers update on the rising clk edge.
- IDLE:
  - start=1 -> DATA. Clears bit index and accumulator; latches odd_mode into mode_q.
  - bit_valid is ignored in IDLE.
  - start and bit_valid in the same cycle: the bit is not consumed.
- DATA:
  - Each bit_valid=1 cycle: shift register[index] <= bit_in; acc <= acc ^ bit_in; index++.
  - When index == DATA_W-1 and bit_valid=1 -> PARITY.
  - bit_valid=0 cycles are stalls: state is held, no timeout.
- PARITY:
  - On bit_valid=1: total = acc ^ bit_in. ok = mode_q ? (total==1) : (total==0).
  - Next edge: done=1 for exactly one cycle, parity_ok=ok, data_out=shift register, state -> IDLE.
- Latency: done is high in the cycle after the parity bit is accepted. A frame takes DATA_W+1 accepted bits.
- Back-to-back frames: start is accepted in the cycle done is high (state is already IDLE).
- Outputs parity_ok and data_out hold until the next completed frame. They are not cleared by start or abort.
- err_count increments by 1 on the same edge that sets done with ok=0. It saturates at 2^CNT_W-1 with no wrap.
- clr_cnt=1 forces err_count to 0 on the next edge. If clr_cnt and an increment coincide, clear wins and the result is 0.
- abort=1 in DATA or PARITY -> IDLE next edge. No done pulse, no counter change, outputs unchanged. abort has priority over bit_valid. abort in IDLE has no effect. abort and start together in IDLE: stay IDLE.
- start while busy is ignored; it does not restart the frame.
- mode changes on odd_mode mid-frame have no effect (mode_q only).
- DATA_W=1: DATA accepts one bit, then PARITY.

Test Plan:
- Reset behaviour: assert rst mid-frame (after 3 of 8 bits) with no clk edge -> busy, done, parity_ok, data_out and err_count all 0 immediately. A following full frame completes normally.
- DATA_W=3, odd mode, exhaustive: for all 8 data values d with parity bit p = ~(^d), then p = ^d -> first case done pulse with parity_ok=1 and data_out=d; second case parity_ok=0. err_count ends at 8.
- DATA_W=8, even mode, data 0xA5 (LSB first) plus parity 0 -> parity_ok=1, data_out=0xA5. Repeat with valid gaps of 0-3 idle cycles between bits -> identical result, done exactly once.
- Back-to-back frames: assert start in the done cycle -> second frame is accepted with no idle cycle. Change odd_mode mid-frame 2 -> result uses the latched mode.
- Abort: abort after 5 data bits -> busy=0 next cycle, no done, err_count unchanged, data_out still shows the previous frame. Abort with bit_valid=1 in PARITY -> no done pulse.
- Counter: CNT_W=2, drive 5 failing frames -> err_count 1,2,3,3,3. Assert clr_cnt on the 6th failing done edge -> err_count=0.

Source files
------------

// File: rtl/parity_frame_checker_if.sv
// Handshake/data bundle between the serial link front-end and the parity frame checker.
interface parity_frame_checker_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
);
  logic              start;
  logic              odd_mode;
  logic              bit_in;
  logic              bit_valid;
  logic              abort;
  logic              clr_cnt;
  logic              busy;
  logic              done;
  logic              parity_ok;
  logic [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output start, odd_mode, bit_in, bit_valid, abort, clr_cnt,
    input  busy, done, parity_ok, data_out, err_count
  );

  modport slave (
    input  start, odd_mode, bit_in, bit_valid, abort, clr_cnt,
    output busy, done, parity_ok, data_out, err_count
  );
endinterface

// File: rtl/parity_frame_checker.sv
// Serial parity frame checker: deserialises DATA_W bits plus a parity bit, flags
// odd/even parity per frame and keeps a saturating count of failed frames.
module parity_frame_checker #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input logic                   clk,
  input logic                   rst,
  parity_frame_checker_if.slave bus
);
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic              acc;
  logic              mode_q;
  logic [DATA_W-1:0] sh;
  logic              done_q;
  logic              ok_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  err_q;
  logic              ok;

  always_comb begin
    ok = 1'b0;
    ok = mode_q ? (acc ^ bus.bit_in) : ~(acc ^ bus.bit_in);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      acc    <= 1'b0;
      mode_q <= 1'b0;
      sh     <= '0;
      done_q <= 1'b0;
      ok_q   <= 1'b0;
      data_q <= '0;
      err_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state  <= DATA;
            idx    <= '0;
            acc    <= 1'b0;
            mode_q <= bus.odd_mode;
          end
        end
        DATA: begin
          if (bus.abort) begin
            state <= IDLE;
          end else if (bus.bit_valid) begin
            sh[idx] <= bus.bit_in;
            acc     <= acc ^ bus.bit_in;
            idx     <= idx + IDX_W'(1);
            if (idx == IDX_W'(DATA_W - 1)) state <= PARITY;
          end
        end
        PARITY: begin
          if (bus.abort) begin
            state <= IDLE;
          end else if (bus.bit_valid) begin
            state  <= IDLE;
            done_q <= 1'b1;
            ok_q   <= ok;
            data_q <= sh;
            if (!ok && (err_q != '1)) err_q <= err_q + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
      // Placed last so a coincident increment loses to the clear.
      if (bus.clr_cnt) err_q <= '0;
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_q;
  assign bus.parity_ok = ok_q;
  assign bus.data_out  = data_q;
  assign bus.err_count = err_q;
endmodule

// File: tb/tb_parity_frame_checker.sv
// Randomised bench for parity_frame_checker: an 8-bit/2-bit-counter instance and a
// 3-bit/8-bit-counter instance share one stimulus set, selected by sel.
module tb_parity_frame_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start, odd_mode, bit_in, bit_valid, abort, clr_cnt;
  logic sel;  // 0 = u8 (DATA_W=8, CNT_W=2), 1 = u3 (DATA_W=3, CNT_W=8)

  parity_frame_checker_if #(.DATA_W(8), .CNT_W(2)) if8 ();
  parity_frame_checker_if #(.DATA_W(3), .CNT_W(8)) if3 ();

  parity_frame_checker #(.DATA_W(8), .CNT_W(2)) u8 (.clk(clk), .rst(rst), .bus(if8));
  parity_frame_checker #(.DATA_W(3), .CNT_W(8)) u3 (.clk(clk), .rst(rst), .bus(if3));

  assign if8.start     = start & ~sel;
  assign if8.odd_mode  = odd_mode;
  assign if8.bit_in    = bit_in;
  assign if8.bit_valid = bit_valid & ~sel;
  assign if8.abort     = abort & ~sel;
  assign if8.clr_cnt   = clr_cnt & ~sel;
  assign if3.start     = start & sel;
  assign if3.odd_mode  = odd_mode;
  assign if3.bit_in    = bit_in;
  assign if3.bit_valid = bit_valid & sel;
  assign if3.abort     = abort & sel;
  assign if3.clr_cnt   = clr_cnt & sel;

  logic       o_busy, o_done, o_ok;
  logic [7:0] o_data, o_cnt;
  always_comb begin
    if (!sel) begin
      o_busy = if8.busy; o_done = if8.done; o_ok = if8.parity_ok;
      o_data = if8.data_out; o_cnt = {6'b0, if8.err_count};
    end else begin
      o_busy = if3.busy; o_done = if3.done; o_ok = if3.parity_ok;
      o_data = {5'b0, if3.data_out}; o_cnt = if3.err_count;
    end
  end

  int tests = 0;
  int fails = 0;

  // Reference model state, per instance.
  int         exp_cnt  [2];
  logic [7:0] exp_data [2];
  logic       exp_ok   [2];

  function automatic int width_of(input logic s);
    return s ? 3 : 8;
  endfunction

  function automatic int max_of(input logic s);
    return s ? 255 : 3;
  endfunction

  // Parity rule: count of ones over data and parity bit must be odd (odd mode) or even.
  function automatic logic model_ok(input logic [7:0] d, input int w, input logic p, input logic m);
    int ones = int'(p);
    for (int i = 0; i < w; i++) ones += int'(d[i]);
    return m ? (ones % 2 == 1) : (ones % 2 == 0);
  endfunction

  function automatic logic bad_parity(input logic [7:0] d, input int w, input logic m);
    return model_ok(d, w, 1'b0, m) ? 1'b1 : 1'b0;
  endfunction

  task automatic model_frame(input logic [7:0] d, input logic p, input logic m, input bit clr);
    int w = width_of(sel);
    exp_data[sel] = d & 8'((1 << w) - 1);
    exp_ok[sel]   = model_ok(d, w, p, m);
    if (clr) exp_cnt[sel] = 0;
    else if (!exp_ok[sel] && exp_cnt[sel] < max_of(sel)) exp_cnt[sel]++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame; a frame that follows directly after another starts in its done cycle.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic m, input int maxgap,
                            input bit flip, input bit clr, output int ndone, output logic got_ok,
                            output logic [7:0] got_data, output logic [7:0] got_cnt,
                            output logic busy_s);
    int w = width_of(sel);
    ndone = 0; got_ok = 1'b0; got_data = '0; got_cnt = '0;
    start = 1'b1; odd_mode = m;
    step();
    start = 1'b0;
    busy_s = o_busy;
    if (o_done) ndone++;
    for (int i = 0; i <= w; i++) begin
      if (flip && i == 2) odd_mode = ~m;
      if (maxgap > 0) begin
        int gaps = int'($urandom_range(maxgap, 0));
        for (int g = 0; g < gaps; g++) begin
          bit_valid = 1'b0; bit_in = $urandom_range(1, 0);
          step();
          if (o_done) ndone++;
        end
      end
      bit_valid = 1'b1;
      bit_in    = (i < w) ? d[i] : p;
      clr_cnt   = clr && (i == w);
      step();
      bit_valid = 1'b0; clr_cnt = 1'b0;
      if (o_done) begin
        ndone++; got_ok = o_ok; got_data = o_data; got_cnt = o_cnt;
      end
    end
    odd_mode = m;
  endtask

  task automatic test_reset();
    int n; logic ok; logic [7:0] dat, cnt; logic b;
    sel = 1'b0; rst = 1'b1;
    step(); step();
    tests++;
    if ({o_busy, o_done, o_ok, o_data, o_cnt} !== 19'd0) begin
      fails++; $display("FAIL reset_state: got busy=%b done=%b ok=%b data=%h cnt=%0d, want all 0",
                        o_busy, o_done, o_ok, o_data, o_cnt);
    end
    rst = 1'b0;
    step();
    send_frame(8'h5A, 1'b1, 1'b1, 0, 1'b0, 1'b0, n, ok, dat, cnt, b);  // even ones + 1 -> odd: ok
    model_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    send_frame(8'h81, 1'b0, 1'b1, 0, 1'b0, 1'b0, n, ok, dat, cnt, b);  // fails odd mode
    model_frame(8'h81, 1'b0, 1'b1, 1'b0);
    // Three data bits in, then an asynchronous reset between edges.
    start = 1'b1; odd_mode = 1'b0; step(); start = 1'b0;
    for (int i = 0; i < 3; i++) begin bit_valid = 1'b1; bit_in = 1'b1; step(); end
    bit_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if ({o_busy, o_done, o_ok, o_data, o_cnt} !== 19'd0) begin
      fails++; $display("FAIL reset_midframe: got busy=%b done=%b ok=%b data=%h cnt=%0d, want all 0",
                        o_busy, o_done, o_ok, o_data, o_cnt);
    end
    #1 rst = 1'b0;
    for (int s = 0; s < 2; s++) begin exp_cnt[s] = 0; exp_data[s] = '0; exp_ok[s] = 1'b0; end
    send_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0, 1'b0, n, ok, dat, cnt, b);
    model_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    tests++;
    if (n !== 1 || ok !== exp_ok[0] || dat !== exp_data[0] || cnt !== exp_cnt[0][7:0]) begin
      fails++; $display("FAIL reset_after_frame: got n=%0d ok=%b data=%h cnt=%0d, want 1 %b %h %0d",
                        n, ok, dat, cnt, exp_ok[0], exp_data[0], exp_cnt[0]);
    end
  endtask

  task automatic test_odd_exhaustive();
    int n; logic ok; logic [7:0] dat, cnt; logic b; logic [7:0] d; logic p;
    sel = 1'b1;
    for (int v = 0; v < 8; v++) begin
      d = 8'(v);
      for (int k = 0; k < 2; k++) begin
        p = (k == 0) ? ~bad_parity(d, 3, 1'b1) : bad_parity(d, 3, 1'b1);
        send_frame(d, p, 1'b1, 0, 1'b0, 1'b0, n, ok, dat, cnt, b);
        model_frame(d, p, 1'b1, 1'b0);
        tests++;
        if (n !== 1 || ok !== exp_ok[1] || dat !== exp_data[1] || cnt !== exp_cnt[1][7:0]) begin
          fails++; $display("FAIL w3_odd d=%0d p=%b: got n=%0d ok=%b data=%h cnt=%0d, want 1 %b %h %0d",
                            v, p, n, ok, dat, cnt, exp_ok[1], exp_data[1], exp_cnt[1]);
        end
      end
    end
    tests++;
    if (o_cnt !== 8'd8) begin
      fails++; $display("FAIL w3_final_count: got %0d, want 8", o_cnt);
    end
  endtask

  task automatic test_even_a5();
    int n; logic ok; logic [7:0] dat, cnt; logic b;
    sel = 1'b0;
    for (int g = 0; g < 2; g++) begin
      send_frame(8'hA5, 1'b0, 1'b0, g * 3, 1'b0, 1'b0, n, ok, dat, cnt, b);
      model_frame(8'hA5, 1'b0, 1'b0, 1'b0);
      tests++;
      if (n !== 1 || ok !== 1'b1 || dat !== 8'hA5 || cnt !== exp_cnt[0][7:0]) begin
        fails++; $display("FAIL even_a5 gaps=%0d: got n=%0d ok=%b data=%h cnt=%0d, want 1 1 a5 %0d",
                          g * 3, n, ok, dat, cnt, exp_cnt[0]);
      end
      step();
      tests++;
      if (o_done !== 1'b0 || o_busy !== 1'b0) begin
        fails++; $display("FAIL even_a5_pulse: got done=%b busy=%b, want 0 0", o_done, o_busy);
      end
    end
  endtask

  task automatic test_random();
    int n; logic ok; logic [7:0] dat, cnt; logic b; logic [7:0] d; logic p, m;
    for (int t = 0; t < 24; t++) begin
      sel = (t % 3 == 2);
      d = 8'($urandom); p = $urandom_range(1, 0); m = $urandom_range(1, 0);
      send_frame(d, p, m, int'($urandom_range(2, 0)), 1'b0, 1'b0, n, ok, dat, cnt, b);
      model_frame(d, p, m, 1'b0);
      tests++;
      if (n !== 1 || ok !== exp_ok[sel] || dat !== exp_data[sel] || cnt !== exp_cnt[sel][7:0]) begin
        fails++; $display("FAIL random t=%0d: got n=%0d ok=%b data=%h cnt=%0d, want 1 %b %h %0d",
                          t, n, ok, dat, cnt, exp_ok[sel], exp_data[sel], exp_cnt[sel]);
      end
      if ($urandom_range(1, 0) == 1) step();
    end
  endtask

  task automatic test_back_to_back();
    int n; logic ok; logic [7:0] dat, cnt; logic b; logic [7:0] d; logic p;
    sel = 1'b0;
    step();
    send_frame(8'h96, 1'b1, 1'b1, 0, 1'b0, 1'b0, n, ok, dat, cnt, b);
    model_frame(8'h96, 1'b1, 1'b1, 1'b0);
    tests++;
    if (o_done !== 1'b1 || ok !== exp_ok[0] || dat !== exp_data[0]) begin
      fails++; $display("FAIL b2b_first: got done=%b ok=%b data=%h, want 1 %b %h",
                        o_done, ok, dat, exp_ok[0], exp_data[0]);
    end
    d = 8'h07; p = ~bad_parity(d, 8, 1'b0);  // passes even mode, fails odd
    send_frame(d, p, 1'b0, 0, 1'b1, 1'b0, n, ok, dat, cnt, b);
    model_frame(d, p, 1'b0, 1'b0);
    tests++;
    if (b !== 1'b1 || n !== 1 || ok !== exp_ok[0] || dat !== exp_data[0] || cnt !== exp_cnt[0][7:0]) begin
      fails++; $display("FAIL b2b_second: got busy=%b n=%0d ok=%b data=%h cnt=%0d, want 1 1 %b %h %0d",
                        b, n, ok, dat, cnt, exp_ok[0], exp_data[0], exp_cnt[0]);
    end
  endtask

  task automatic test_abort();
    int ndone;
    sel = 1'b0;
    step();
    start = 1'b1; odd_mode = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin bit_valid = 1'b1; bit_in = $urandom_range(1, 0); step(); end
    bit_valid = 1'b0; abort = 1'b1; step(); abort = 1'b0;
    tests++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_cnt !== exp_cnt[0][7:0] || o_data !== exp_data[0]
        || o_ok !== exp_ok[0]) begin
      fails++; $display("FAIL abort_data: got busy=%b done=%b cnt=%0d data=%h ok=%b, want 0 0 %0d %h %b",
                        o_busy, o_done, o_cnt, o_data, o_ok, exp_cnt[0], exp_data[0], exp_ok[0]);
    end
    // Abort competing with the parity bit.
    start = 1'b1; odd_mode = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 8; i++) begin bit_valid = 1'b1; bit_in = 1'b0; step(); end
    abort = 1'b1; bit_in = 1'b0; step(); abort = 1'b0; bit_valid = 1'b0;
    ndone = int'(o_done);
    for (int i = 0; i < 3; i++) begin step(); ndone += int'(o_done); end
    tests++;
    if (ndone !== 0 || o_busy !== 1'b0 || o_cnt !== exp_cnt[0][7:0] || o_data !== exp_data[0]) begin
      fails++; $display("FAIL abort_parity: got dones=%0d busy=%b cnt=%0d data=%h, want 0 0 %0d %h",
                        ndone, o_busy, o_cnt, o_data, exp_cnt[0], exp_data[0]);
    end
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    tests++;
    if (o_busy !== 1'b0) begin
      fails++; $display("FAIL abort_start_idle: got busy=%b, want 0", o_busy);
    end
  endtask

  task automatic test_counter();
    int n; logic ok; logic [7:0] dat, cnt; logic b; logic [7:0] d; logic m;
    sel = 1'b0;
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    exp_cnt[0] = 0;
    tests++;
    if (o_cnt !== 8'd0) begin
      fails++; $display("FAIL cnt_clear: got %0d, want 0", o_cnt);
    end
    for (int f = 0; f < 6; f++) begin
      d = 8'($urandom); m = $urandom_range(1, 0);
      send_frame(d, bad_parity(d, 8, m), m, 1, 1'b0, f == 5, n, ok, dat, cnt, b);
      model_frame(d, bad_parity(d, 8, m), m, f == 5);
      tests++;
      if (n !== 1 || ok !== 1'b0 || cnt !== exp_cnt[0][7:0]) begin
        fails++; $display("FAIL cnt_sat f=%0d: got n=%0d ok=%b cnt=%0d, want 1 0 %0d",
                          f, n, ok, cnt, exp_cnt[0]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0;
    start = 1'b0; odd_mode = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; abort = 1'b0; clr_cnt = 1'b0;
    for (int s = 0; s < 2; s++) begin exp_cnt[s] = 0; exp_data[s] = '0; exp_ok[s] = 1'b0; end
    test_reset();
    test_odd_exhaustive();
    test_even_a5();
    test_random();
    test_back_to_back();
    test_abort();
    test_counter();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
